req_arbiter: RTL and testbench
==============================

# req_arbiter

Upstream request stage for the `dut` req/gnt handshake block. It collects level requests from `N_CLIENTS` clients and picks one winner round-robin. It then drives the single `req` line into `dut`, waits for `gnt`, and returns a one-cycle grant pulse to the winning client. This serialises multiple requesters onto one handshake channel, with an optional timeout watchdog for the case where `gnt` never arrives.

## Interface
- `N_CLIENTS`, default 4: number of requesting clients, range 2..16.
- `TIMEOUT`, default 8: number of cycles in `WAIT` without `gnt` before abort. Used only with `REQ_TIMEOUT_EN`. Minimum 1.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `client_req` in `N_CLIENTS`: per-client level request. The client holds it until its `client_gnt` pulse.
- `client_gnt` out `N_CLIENTS`: one-hot, one-cycle grant pulse to the served client.
- `req` out 1: request to `dut`. Registered.
- `gnt` in 1: grant from `dut`.
- `busy` out 1: high in any state other than `IDLE`.
- `spurious_gnt` out 1: one-cycle pulse when `gnt` is sampled high outside `WAIT`.
- `timeout_err` out 1: one-cycle pulse on a timeout abort. Tied 0 without `REQ_TIMEOUT_EN`.

## Operation
- State machine has three states: `IDLE`, `WAIT`, `RELEASE`.
- `IDLE`
  - Requires `req`=0.
  - If `client_req` != 0 at a rising edge: latch the winner index and go to `WAIT`.
  - Otherwise stay in `IDLE`.
- Winner selection
  - The winner is the first set bit of `client_req`, searching upward from `rr_ptr` and wrapping at `N_CLIENTS`-1 back to 0.
- `WAIT`
  - Requires `req`=1.
  - On `gnt`=1 at an edge: pulse `client_gnt[winner]`, set `rr_ptr` = winner+1 modulo `N_CLIENTS`, go to `RELEASE`.
- `RELEASE`
  - Requires `req`=0 for exactly one cycle, so `dut` always sees a falling edge between transactions.
  - Then go to `IDLE`.
- The latched winner is served even if its `client_req` drops during `WAIT`. The grant is still pulsed.
- `rr_ptr` advances only on a completed grant or a timeout abort. It never advances in `IDLE`.
- `gnt` sampled high in `IDLE` or `RELEASE` is ignored for state, and pulses `spurious_gnt`.
- Reset value of every output and register: `req`=0, `client_gnt`=0, `busy`=0, `spurious_gnt`=0, `timeout_err`=0, state `IDLE`, `rr_ptr`=0, timeout counter 0.
- Reset asserted mid-transaction drops `req` immediately (asynchronously). No grant is issued for the aborted transaction.

## Timing
- Let `client_req` be sampled at edge t, with state `IDLE`.
  - `req`=1 from edge t+1.
  - `busy`=1 from edge t+1.
- Let `gnt` be sampled high at edge k, with state `WAIT`.
  - `client_gnt[winner]`=1 during cycle k..k+1 only.
  - `req`=0 from edge k+1.
- `RELEASE` occupies k+1..k+2. `IDLE` resumes at k+2. The earliest next `req` rise is edge k+3.
- If `gnt` is already high on the first `WAIT` edge (t+1), the grant is issued then. The minimum transaction is 4 cycles, from `IDLE` sample to the next possible `req`.
- `client_gnt`, `spurious_gnt` and `timeout_err` are all registered outputs.

## Configuration
- Macro: `REQ_TIMEOUT_EN`.
- Defined
  - A counter of width `$clog2(TIMEOUT+1)` clears on `WAIT` entry and increments on each `WAIT` edge without `gnt`.
  - When the counter equals `TIMEOUT` with no `gnt`: pulse `timeout_err`, issue no `client_gnt`, advance `rr_ptr` past the winner, go to `RELEASE`.
  - `gnt` arriving on the same edge as expiry wins: a normal grant is issued and there is no error.
- Not defined
  - No counter. `WAIT` holds indefinitely until `gnt`. `timeout_err` is tied to 0.

## Structure
- Package `arb_pkg`:
  - `state_t` enum (`IDLE`, `WAIT`, `RELEASE`).
  - Default `N_CLIENTS` / `TIMEOUT` localparams.
  - Pointer-width function.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: winner index, valid.
- `req_arbiter` holds the FSM, the winner register, `rr_ptr` and the optional timeout counter.

## Test plan
- After reset, `client_req`=4'b0000 for 5 cycles → `req`=0, `busy`=0, all outputs 0.
- `client_req`=4'b0010, `dut` grants 2 cycles after `req` rises → `req` high 2 cycles, `client_gnt`=4'b0010 for one cycle, `req` low ≥1 cycle.
- `client_req`=4'b1111 held → grants served in order 0,1,2,3,0; consecutive `req` pulses separated by ≥1 low cycle.
- `gnt` forced high while `IDLE` → `spurious_gnt` pulses, state stays `IDLE`, no `client_gnt`.
- With `REQ_TIMEOUT_EN`, `TIMEOUT`=8, `gnt` held 0 and `client_req`=4'b0001:
  - `timeout_err` pulses 8 cycles after `req` rises.
  - `req` drops, `client_gnt` stays 0, next winner search starts at client 1.
- `rst` asserted 1 cycle into `WAIT` → `req`=0 immediately, no `client_gnt`, `rr_ptr`=0 after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin request arbiter.
// The optional timeout watchdog is enabled by defining REQ_TIMEOUT_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEFAULT_N_CLIENTS = 4;
  localparam int DEFAULT_TIMEOUT   = 8;

  // A client index needs at least one bit, even for two clients
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping from the top client back to client 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_CLIENTS = DEFAULT_N_CLIENTS,
  parameter int PTR_W     = ptr_width(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req_vec_i,
  input  logic [PTR_W-1:0]     rr_ptr_i,
  output logic [PTR_W-1:0]     winner_o,
  output logic                 valid_o
);

  int               pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    pos      = 0;
    idx      = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      pos = int'(rr_ptr_i) + i;
      if (pos >= N_CLIENTS) begin
        pos = pos - N_CLIENTS;
      end
      idx = PTR_W'(pos);
      if (!valid_o && req_vec_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Serialises N_CLIENTS level requesters onto one req/gnt handshake channel.
// Define REQ_TIMEOUT_EN to add a watchdog that aborts a WAIT lasting TIMEOUT cycles.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N_CLIENTS = DEFAULT_N_CLIENTS,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] client_req,
  output logic [N_CLIENTS-1:0] client_gnt,
  output logic                 req,
  input  logic                 gnt,
  output logic                 busy,
  output logic                 spurious_gnt,
  output logic                 timeout_err
);

  localparam int PTR_W = ptr_width(N_CLIENTS);

  state_t               state_q;
  logic                 req_q;
  logic                 busy_q;
  logic                 spurious_q;
  logic [N_CLIENTS-1:0] client_gnt_q;
  logic [PTR_W-1:0]     winner_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [N_CLIENTS-1:0] grant_vec_d;
  logic [PTR_W-1:0]     pick_winner;
  logic                 pick_valid;

  rr_pick #(
    .N_CLIENTS (N_CLIENTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req_vec_i (client_req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (pick_winner),
    .valid_o   (pick_valid)
  );

  // Both a completed grant and a timeout abort move the pointer past the winner
  assign rr_ptr_d = (winner_q == PTR_W'(N_CLIENTS - 1)) ? '0 : winner_q + PTR_W'(1);

  always_comb begin
    grant_vec_d           = '0;
    grant_vec_d[winner_q] = 1'b1;
  end

`ifdef REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire;
  logic             timeout_q;

  assign cnt_d       = cnt_q + CNT_W'(1);
  assign expire      = (cnt_d == CNT_W'(TIMEOUT));
  assign timeout_err = timeout_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      spurious_q   <= 1'b0;
      client_gnt_q <= '0;
      winner_q     <= '0;
      rr_ptr_q     <= '0;
`ifdef REQ_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      client_gnt_q <= '0;
      spurious_q   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          spurious_q <= gnt;
          if (pick_valid) begin
            winner_q <= pick_winner;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
`ifdef REQ_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        WAIT: begin
          // A gnt on the expiry edge still counts as a normal grant
          if (gnt) begin
            client_gnt_q <= grant_vec_d;
            rr_ptr_q     <= rr_ptr_d;
            req_q        <= 1'b0;
            state_q      <= RELEASE;
          end
`ifdef REQ_TIMEOUT_EN
          else if (expire) begin
            timeout_q <= 1'b1;
            rr_ptr_q  <= rr_ptr_d;
            req_q     <= 1'b0;
            cnt_q     <= cnt_d;
            state_q   <= RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end
        RELEASE: begin
          spurious_q <= gnt;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req          = req_q;
  assign busy         = busy_q;
  assign spurious_gnt = spurious_q;
  assign client_gnt   = client_gnt_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_req_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
`ifdef REQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] clientReq;
  logic [N-1:0] clientGnt;
  logic         reqOut;
  logic         gntIn;
  logic         busyOut;
  logic         spurOut;
  logic         terrOut;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  req_arbiter #(
    .N_CLIENTS (N),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .client_req   (clientReq),
    .client_gnt   (clientGnt),
    .req          (reqOut),
    .gnt          (gntIn),
    .busy         (busyOut),
    .spurious_gnt (spurOut),
    .timeout_err  (terrOut)
  );

  typedef struct {
    logic [N-1:0] cr;
    logic         g;
    logic         eReq;
    logic [N-1:0] eGnt;
    logic         eBusy;
    logic         eSpur;
  } vec_t;

  vec_t tbl[18];

  // Transaction-level reference: phase 0 idle, 1 waiting for gnt, 2 release gap
  int           mPhase, mPtr, mWin, mMiss;
  logic         expReq, expBusy, expSpur, expTerr;
  logic [N-1:0] expGnt;

  function automatic int firstFrom(input logic [N-1:0] cr, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (cr[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mPhase = 0; mPtr = 0; mWin = 0; mMiss = 0;
    expReq = 0; expBusy = 0; expSpur = 0; expTerr = 0; expGnt = '0;
  endtask

  task automatic modelEdge(input logic [N-1:0] cr, input logic g);
    expGnt = '0; expSpur = 0; expTerr = 0;
    case (mPhase)
      0: begin
        expSpur = g;
        if (cr != '0) begin
          mWin = firstFrom(cr, mPtr); mMiss = 0; mPhase = 1;
        end
      end
      1: begin
        if (g) begin
          expGnt = N'(1 << mWin); mPtr = (mWin + 1) % N; mPhase = 2;
        end else if (TMO_EN) begin
          mMiss++;
          if (mMiss == TMO) begin
            expTerr = 1; mPtr = (mWin + 1) % N; mPhase = 2;
          end
        end
      end
      default: begin
        expSpur = g; mPhase = 0;
      end
    endcase
    expReq  = (mPhase == 1);
    expBusy = (mPhase != 0);
  endtask

  task automatic applyStimulus(input logic [N-1:0] cr, input logic g);
    clientReq = cr;
    gntIn     = g;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic [N-1:0] eGnt,
                             input logic eBusy, input logic eSpur, input logic eTerr);
    nVec++;
    if ({reqOut, clientGnt, busyOut, spurOut, terrOut} !== {eReq, eGnt, eBusy, eSpur, eTerr}) begin
      nMis++;
      $display("[TB] FAIL %s: got req=%b gnt=%b busy=%b spur=%b terr=%b, want req=%b gnt=%b busy=%b spur=%b terr=%b",
               name, reqOut, clientGnt, busyOut, spurOut, terrOut, eReq, eGnt, eBusy, eSpur, eTerr);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; clientReq = '0; gntIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 0, '0, 0, 0, 0);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] rrOrder[5];
    logic [N-1:0] cr;
    int           got;
    bit           gap;

    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[6]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b1001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[12] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[13] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1};
    tbl[16] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

    rrOrder[0] = 4'b0001; rrOrder[1] = 4'b0010; rrOrder[2] = 4'b0100;
    rrOrder[3] = 4'b1000; rrOrder[4] = 4'b0001;

    $display("[TB] directed vector table");
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].cr, tbl[i].g);
      checkOutput($sformatf("tbl[%0d]", i), tbl[i].eReq, tbl[i].eGnt, tbl[i].eBusy, tbl[i].eSpur, 1'b0);
    end

    $display("[TB] round-robin order with all clients requesting");
    doReset();
    got = 0; gap = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      applyStimulus(4'b1111, 1'b1);
      if (gap) begin
        checkValue("rr_gap_req_low", {7'd0, reqOut}, 8'd0);
        gap = 0;
      end
      if (clientGnt != '0) begin
        checkValue($sformatf("rr_grant[%0d]", got), {4'd0, clientGnt}, {4'd0, rrOrder[got]});
        checkValue("rr_req_low_at_grant", {7'd0, reqOut}, 8'd0);
        got++;
        gap = 1;
      end
    end
    if (got < 5) begin
      nVec++; nMis++;
      $display("[TB] FAIL rr_budget: got %0d grants, want 5", got);
    end

    $display("[TB] reset during WAIT");
    doReset();
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("pre_rst_grant", 0, 4'b0001, 1, 0, 0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("pre_rst_wait", 1, 4'b0000, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_drop", 0, 4'b0000, 0, 0, 0);
    clientReq = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_no_grant", 0, 4'b0000, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rst_ptr_zero", 0, 4'b0001, 1, 0, 0);
    applyStimulus(4'b0000, 1'b0);

`ifdef REQ_TIMEOUT_EN
    $display("[TB] timeout abort");
    doReset();
    applyStimulus(4'b0001, 1'b0);
    checkOutput("to_req_rise", 1, 4'b0000, 1, 0, 0);
    for (int i = 1; i <= TMO; i++) begin
      applyStimulus(4'b0001, 1'b0);
      if (i < TMO) checkOutput($sformatf("to_wait[%0d]", i), 1, 4'b0000, 1, 0, 0);
      else         checkOutput("to_expire", 0, 4'b0000, 1, 0, 1);
    end
    applyStimulus(4'b0011, 1'b0);
    checkOutput("to_release", 0, 4'b0000, 0, 0, 0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("to_next_winner", 0, 4'b0010, 1, 0, 0);
    applyStimulus(4'b0000, 1'b0);
`endif

    $display("[TB] randomized run against reference model");
    doReset();
    cr = '0;
    for (int c = 0; c < 400; c++) begin
      logic g;
      logic [N-1:0] granted;
      g = ($urandom_range(0, 9) < 4);
      modelEdge(cr, g);
      applyStimulus(cr, g);
      checkOutput($sformatf("rand[%0d]", c), expReq, expGnt, expBusy, expSpur, expTerr);
      granted = clientGnt;
      for (int j = 0; j < N; j++) begin
        if (granted[j]) cr[j] = 1'b0;
        else if (!cr[j] && $urandom_range(0, 3) == 0) cr[j] = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
